ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader.sv | 174 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streams `count` consecutive RAM words starting at `base` onto a ready/valid port.
// Optional bounds check against ram_length is enabled by defining RAM_STREAM_READER_BOUNDS_CHECK_EN.
module ram_stream_reader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [31:0]      count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      ram_address,
    output logic             ram_oe,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      ram_length,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_addr;
    logic [31:0]      r_issue_left;
    logic [31:0]      r_beats_left;
    logic             r_inflight;
    logic [1:0]       r_buf_cnt;
    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;

    logic             w_pop;
    logic             w_issue;
    logic             w_reject;
    logic [2:0]       w_occ;

`ifdef RAM_STREAM_READER_BOUNDS_CHECK_EN
    logic             r_error;
    logic [32:0]      w_end;

    assign w_end    = {1'b0, base} + {1'b0, count};
    assign w_reject = (w_end > {1'b0, ram_length});

    // Sticky until the next accepted start re-evaluates it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_error <= w_reject;
        end
    end

    assign error = r_error;
`else
    logic w_unused_len;

    assign w_unused_len = ^ram_length;
    assign w_reject     = 1'b0;
    assign error        = 1'b0;
`endif

    assign m_valid = (r_buf_cnt != 2'd0);
    assign w_pop   = m_valid && m_ready;

    // Buffered words plus the read whose data is on ram_dout this cycle.
    assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_inflight};
    assign w_issue = (r_state == RUN) && (r_issue_left != 32'd0) &&
                     ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

    assign ram_oe      = w_issue;
    assign ram_address = r_addr;
    assign ram_we      = 1'b0;
    assign ram_din     = '0;
    assign m_data      = r_buf0;
    assign busy        = r_busy;
    assign done        = r_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr       <= 32'd0;
            r_issue_left <= 32'd0;
            r_beats_left <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr       <= base;
                        r_issue_left <= count;
                        r_beats_left <= count;
                        if (w_reject || count == 32'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_addr       <= r_addr + 32'd1;
                        r_issue_left <= r_issue_left - 32'd1;
                    end
                    if (w_pop) begin
                        r_beats_left <= r_beats_left - 32'd1;
                        if (r_beats_left == 32'd1) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry in-order buffer; r_buf0 is always the head presented on m_data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_issue;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_buf_cnt == 2'd0) begin
                        r_buf0 <= ram_dout;
                    end else begin
                        r_buf1 <= ram_dout;
                    end
                    r_buf_cnt <= r_buf_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0    <= r_buf1;
                    r_buf_cnt <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_buf_cnt == 2'd1) begin
                        r_buf0 <= ram_dout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= ram_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader against a word-list reference model and a behavioural RAM.
// Build with RAM_STREAM_READER_BOUNDS_CHECK_EN defined to exercise the bounds check.
module tb_ram_stream_reader;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      base = 32'd0;
    logic [31:0]      count = 32'd0;
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      ram_address;
    logic             ram_oe;
    logic             ram_we;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_dout = '0;
    logic [31:0]      ram_length = 32'd0;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;

    logic [31:0]      salt = 32'd0;
    int               n_chk = 0;
    int               n_err = 0;

    ram_stream_reader #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .busy(busy), .done(done), .error(error),
        .ram_address(ram_address), .ram_oe(ram_oe), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_length(ram_length),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ramf(input logic [31:0] a);
        return WIDTH'((a * 32'd3) ^ salt);
    endfunction

    // RAM: data one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (ram_oe) ram_dout <= ramf(ram_address);
        else        ram_dout <= WIDTH'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int rel);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (rel % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // One transfer; cycle 0 is the cycle in which start is sampled.
    task automatic xfer(input logic [31:0] b, input logic [31:0] n, input int mode,
                        input bit hold, input bit oob);
        int issued, delivered, first_v, last_b, done_cyc, occ;
        bit prev_stall;
        logic [WIDTH-1:0] prev_data;
        logic [31:0] nexp;
        nexp = oob ? 32'd0 : n;
        issued = 0; delivered = 0; first_v = -1; last_b = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_data = '0;
        @(posedge clk); #1;
        start = 1'b1; base = b; count = n; m_ready = rdy(mode, 0);
        for (int rel = 0; rel < 400 && done_cyc < 0; rel++) begin
            if (rel > 0) begin
                @(posedge clk); #1;
                start = hold;
                if (hold) begin
                    base  = $urandom;
                    count = $urandom;
                end
                m_ready = rdy(mode, rel);
            end
            @(negedge clk);
            occ = issued - delivered;
            chk("occ_le2", 64'(occ <= 2), 64'd1);
            if (rel == 1) begin
                chk("busy_c1", 64'(busy), 64'(nexp != 32'd0));
                if (!oob) chk("err_clr", 64'(error), 64'd0);
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(prev_data));
            end
            if (ram_oe) begin
                chk("rd_addr", 64'(ram_address), 64'(32'(b + 32'(issued))));
                issued++;
            end
            if (m_valid && first_v < 0) first_v = rel;
            if (m_valid && m_ready) begin
                chk("beat_data", 64'(m_data), 64'(ramf(32'(b + 32'(delivered)))));
                delivered++;
                last_b = rel;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) begin
                done_cyc = rel;
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_err", 64'(error), 64'(oob));
            end
        end
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("beats", 64'(delivered), 64'(nexp));
        chk("reads", 64'(issued), 64'(nexp));
        if (nexp == 32'd0) begin
            chk("lat_done0", 64'(done_cyc), 64'd1);
            chk("no_valid", 64'(first_v), 64'(-1));
        end else if (mode == 0) begin
            chk("lat_first", 64'(first_v), 64'd3);
            chk("lat_last", 64'(last_b), 64'(int'(n) + 2));
            chk("lat_done", 64'(done_cyc), 64'(int'(n) + 3));
        end
        @(posedge clk); #1;
        start = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        chk("post_done", 64'(done), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_valid", 64'(m_valid), 64'd0);
        chk("post_err", 64'(error), 64'(oob));
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_done"}, 64'(done), 64'd0);
        chk({pfx, "_err"}, 64'(error), 64'd0);
        chk({pfx, "_valid"}, 64'(m_valid), 64'd0);
        chk({pfx, "_oe"}, 64'(ram_oe), 64'd0);
        chk({pfx, "_addr"}, 64'(ram_address), 64'd0);
        chk({pfx, "_data"}, 64'(m_data), 64'd0);
        chk({pfx, "_we"}, 64'(ram_we), 64'd0);
        chk({pfx, "_din"}, 64'(ram_din), 64'd0);
    endtask

    initial begin
        bit seen;
        logic [31:0] rb, rn;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst0");

`ifdef RAM_STREAM_READER_BOUNDS_CHECK_EN
        ram_length = 32'h8000_0000;
`else
        ram_length = $urandom;
`endif
        salt = 32'd0;
        xfer(32'h10, 32'd4, 0, 1'b0, 1'b0);
        xfer(32'h100, 32'd8, 1, 1'b0, 1'b0);
        xfer(32'h40, 32'd0, 0, 1'b0, 1'b0);
        xfer(32'h80, 32'd5, 0, 1'b1, 1'b0);
`ifndef RAM_STREAM_READER_BOUNDS_CHECK_EN
        xfer(32'hFFFF_FFFE, 32'd3, 0, 1'b0, 1'b0);
`endif

        // Abort a count=10 transfer with reset low in cycle 5.
        @(posedge clk); #1;
        start = 1'b1; base = 32'h300; count = 32'd10; m_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            reset = (c != 5);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort");
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || m_valid || ram_oe) seen = 1'b1;
        end
        chk("abort_quiet", 64'(seen), 64'd0);
        xfer(32'h500, 32'd2, 0, 1'b0, 1'b0);

`ifdef RAM_STREAM_READER_BOUNDS_CHECK_EN
        ram_length = 32'd1024;
        xfer(32'd1020, 32'd8, 0, 1'b0, 1'b1);
        xfer(32'd1016, 32'd8, 0, 1'b0, 1'b0);
        ram_length = 32'h8000_0000;
`endif

        for (int t = 0; t < 14; t++) begin
            salt = $urandom;
`ifdef RAM_STREAM_READER_BOUNDS_CHECK_EN
            rb = 32'($urandom_range(0, 1 << 20));
`else
            rb = $urandom;
            if (t % 4 == 0) rb = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
`endif
            rn = 32'($urandom_range(0, 12));
            xfer(rb, rn, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
